// File: rtl/dsp_systolic_result_collector.sv
// Result-side collector for the 18x18 systolic MAC chain: realigns valid/last tags with
// chain results, sums multi-beat vectors and queues finished sums in a small FWFT buffer.
module dsp_systolic_result_collector #(
    parameter int unsigned RES_LATENCY    = 2,
    parameter int unsigned RESULT_A_WIDTH = 64,
    parameter int unsigned ACC_WIDTH      = 72,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic [RESULT_A_WIDTH-1:0] result,
    output logic [ACC_WIDTH-1:0]      out_data,
    output logic                      out_ovf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      drop,
    input  logic                      clear_flags
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Tag pipe: bit 1 = valid, bit 0 = last (masked by valid on entry)
    logic [1:0] tag_q [RES_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q[0] <= '0;
        end else begin
            tag_q[0] <= {in_valid, in_valid & in_last};
        end
    end

    for (genvar gi = 1; gi < RES_LATENCY; gi++) begin : g_tag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q[gi] <= '0;
            end else begin
                tag_q[gi] <= tag_q[gi-1];
            end
        end
    end

    logic exit_vld;
    logic exit_last;
    assign exit_vld  = tag_q[RES_LATENCY-1][1];
    assign exit_last = tag_q[RES_LATENCY-1][0];

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 first_q, first_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_next;
    logic                 push;

    always_comb begin
        sum      = {1'b0, (first_q ? {ACC_WIDTH{1'b0}} : acc_q)}
                 + {{(ACC_WIDTH + 1 - RESULT_A_WIDTH){1'b0}}, result};
        ovf_next = (~first_q & ovf_q) | sum[ACC_WIDTH];
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        first_d  = first_q;
        if (exit_vld) begin
            acc_d   = sum[ACC_WIDTH-1:0];
            ovf_d   = ovf_next;
            first_d = exit_last;
        end
        push = exit_vld & exit_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
        end else begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            first_q <= first_d;
        end
    end

    logic [ACC_WIDTH:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               drop_q, drop_d;
    logic               pop;
    logic               push_ok;
    logic               full;

    // A full buffer still accepts a push when the head leaves in the same cycle
    always_comb begin
        full    = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop     = (cnt_q != '0) & out_ready;
        push_ok = push & (~full | pop);
        wr_d    = wr_q + PTR_W'(push_ok);
        rd_d    = rd_q + PTR_W'(pop);
        cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        drop_d  = clear_flags ? 1'b0 : drop_q;
        if (push && !push_ok) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= {sum[ACC_WIDTH-1:0], ovf_next};
        end
    end

    logic [ACC_WIDTH:0] head;
    always_comb begin
        head      = mem_q[rd_q];
        out_valid = (cnt_q != '0);
        out_data  = out_valid ? head[ACC_WIDTH:1] : '0;
        out_ovf   = out_valid & head[0];
        drop      = drop_q;
    end

endmodule

// File: tb/tb_dsp_systolic_result_collector.sv
// Directed bench for dsp_systolic_result_collector: a 72-bit and a 64-bit accumulator
// instance share stimulus fed through a model of the chain's result latency.
module tb_dsp_systolic_result_collector;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [63:0] op_res = 64'hDEAD;
    logic [63:0] result;
    logic        out_ready = 1'b0;
    logic        clear_flags = 1'b0;

    logic [71:0] data72;
    logic        ovf72, valid72, drop72;
    logic [63:0] data64;
    logic        ovf64, valid64, drop64;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    always #5 clk = ~clk;

    // Chain model: result for operands sampled at an edge appears L cycles later
    logic [63:0] res_pipe [L];
    always @(posedge clk) begin
        res_pipe[0] <= op_res;
        for (int i = 1; i < int'(L); i++) res_pipe[i] <= res_pipe[i-1];
    end
    assign result = res_pipe[L-1];

    dsp_systolic_result_collector #(
        .RES_LATENCY(L), .RESULT_A_WIDTH(64), .ACC_WIDTH(72), .FIFO_DEPTH(4)
    ) u_dut72 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .result(result), .out_data(data72), .out_ovf(ovf72), .out_valid(valid72),
        .out_ready(out_ready), .drop(drop72), .clear_flags(clear_flags)
    );

    dsp_systolic_result_collector #(
        .RES_LATENCY(L), .RESULT_A_WIDTH(64), .ACC_WIDTH(64), .FIFO_DEPTH(4)
    ) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
        .result(result), .out_data(data64), .out_ovf(ovf64), .out_valid(valid64),
        .out_ready(out_ready), .drop(drop64), .clear_flags(clear_flags)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic l, input logic [63:0] r);
        in_valid = v;
        in_last  = l;
        op_res   = r;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        op_res   = 64'hDEAD;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", 72'(valid72), 72'd0);
        chk("rst_drop",  72'(drop72),  72'd0);
        chk("rst_data",  data72,       72'd0);
        chk("rst_ovf",   72'(ovf72),   72'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-beat vector: out_valid exactly RES_LATENCY+1 cycles later
        beat(1'b1, 1'b1, 64'h3_FFFC_0001);
        chk("single_early", 72'(valid72), 72'd0);
        tick();
        chk("single_early2", 72'(valid72), 72'd0);
        tick();
        chk("single_valid", 72'(valid72), 72'd1);
        chk("single_data",  data72,       72'h3_FFFC_0001);
        chk("single_ovf",   72'(ovf72),   72'd0);
        pop_one();
        chk("single_popped", 72'(valid72), 72'd0);

        // Three beats with a gap; invalid-cycle results (0xDEAD) must be ignored
        beat(1'b1, 1'b0, 64'd10);
        beat(1'b1, 1'b0, 64'd20);
        beat(1'b0, 1'b0, 64'hDEAD);
        chk("vec_mid1", 72'(valid72), 72'd0);
        beat(1'b1, 1'b1, 64'd30);
        chk("vec_mid2", 72'(valid72), 72'd0);
        tick();
        chk("vec_mid3", 72'(valid72), 72'd0);
        tick();
        chk("vec_valid", 72'(valid72), 72'd1);
        chk("vec_data",  data72,       72'd60);
        pop_one();
        chk("vec_popped", 72'(valid72), 72'd0);

        // Overfill: 5 pushes into a 4-entry buffer
        for (int i = 1; i <= 5; i++) beat(1'b1, 1'b1, 64'(i));
        tick();
        tick();
        tick();
        chk("full_drop",  72'(drop72), 72'd1);
        chk("full_head",  data72,      72'd1);
        tick();
        chk("full_stable", data72,     72'd1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", data72, 72'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 72'(valid72), 72'd0);
        chk("drop_sticky", 72'(drop72),  72'd1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("drop_clear", 72'(drop72), 72'd0);

        // Full buffer with a simultaneous push and pop
        for (int i = 11; i <= 14; i++) beat(1'b1, 1'b1, 64'(i));
        tick();
        tick();
        chk("fill_head", data72, 72'd11);
        beat(1'b1, 1'b1, 64'd7);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_drop", 72'(drop72), 72'd0);
        chk("pp_head", data72,      72'd12);
        out_ready = 1'b1;
        chk("pp_e0", data72, 72'd12); tick();
        chk("pp_e1", data72, 72'd13); tick();
        chk("pp_e2", data72, 72'd14); tick();
        chk("pp_e3", data72, 72'd7);  tick();
        out_ready = 1'b0;
        chk("pp_empty", 72'(valid72), 72'd0);
        chk("pp_drop2", 72'(drop72),  72'd0);

        // Overflow: 64-bit accumulator wraps, 72-bit does not
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        beat(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        tick();
        chk("ovf64_data",  72'(data64), 72'h0_FFFF_FFFF_FFFF_FFFE);
        chk("ovf64_flag",  72'(ovf64),  72'd1);
        chk("ovf72_data",  data72,      72'h1_FFFF_FFFF_FFFF_FFFE);
        chk("ovf72_flag",  72'(ovf72),  72'd0);
        pop_one();
        beat(1'b1, 1'b1, 64'd5);
        tick();
        tick();
        chk("post_ovf_data", 72'(data64), 72'd5);
        chk("post_ovf_flag", 72'(ovf64),  72'd0);
        pop_one();
        chk("ovf_empty", 72'(valid64), 72'd0);

        // Reset mid-vector with beats in flight
        beat(1'b1, 1'b0, 64'd100);
        beat(1'b1, 1'b0, 64'd200);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 72'(valid72), 72'd0);
        tick();
        rst_n = 1'b1;
        beat(1'b1, 1'b1, 64'd9);
        chk("mrst_nospur1", 72'(valid72), 72'd0);
        tick();
        chk("mrst_nospur2", 72'(valid72), 72'd0);
        tick();
        chk("mrst_valid9", 72'(valid72), 72'd1);
        chk("mrst_data9",  data72,       72'd9);
        pop_one();
        tick();
        chk("mrst_empty", 72'(valid72), 72'd0);
        chk("mrst_drop",  72'(drop72),  72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dsp_systolic_result_collector.md
Name: dsp_systolic_result_collector

Overview:
- Consumer end of the 18x18 unsigned systolic multiply-accumulate chain.
- Tracks which chain results are valid by delaying operand-side valid/last tags by the chain latency.
- Accumulates consecutive valid results into long dot products (multi-beat vectors).
- Delivers each finished sum through a small first-word-fall-through buffer with a valid/ready handshake; the chain itself never stalls.

Parameters:
- RES_LATENCY, 2, cycles from operands (with in_valid) sampled at chain input to the matching value on result; legal range 1..16.
- RESULT_A_WIDTH, 64, width of chain result.
- ACC_WIDTH, 72, accumulator/output width; must be >= RESULT_A_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; power of two, 2..16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented to chain this cycle are a valid beat.
- in_last  in  1  this beat ends the current vector; ignored when in_valid=0.
- result  in  RESULT_A_WIDTH  chain output, unsigned.
- out_data  out  ACC_WIDTH  completed vector sum (head of buffer).
- out_ovf  out  1  head sum overflowed ACC_WIDTH.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- drop  out  1  sticky: a completed sum was lost because the buffer was full.
- clear_flags  in  1  synchronous clear of drop.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled by the caller): tag pipe cleared; accumulator = 0; first-beat flag = 1; buffer empty.
  - Outputs at reset: out_valid=0, out_data=0, out_ovf=0, drop=0.
- Tag pipe:
  - RES_LATENCY-stage shift register of {in_valid, in_last}; advances every cycle.
  - A tag exits stage RES_LATENCY-1 in the same cycle its result is on the result port.
- Accumulate, when the exiting tag is valid:
  - sum = (first ? 0 : acc) + zero-extend(result) to ACC_WIDTH+1 bits.
  - ovf_run = (first ? 0 : ovf_run) | sum[ACC_WIDTH].
  - acc <= sum[ACC_WIDTH-1:0]; first <= tag.last.
- Exiting tag invalid: acc, ovf_run, first hold. Gaps inside a vector are allowed.
- Completion (exiting tag valid and last):
  - Push {sum[ACC_WIDTH-1:0], ovf_run_next} into the buffer in the same cycle.
  - Earliest out_valid is the next cycle. Latency from last beat at chain input to out_valid = RES_LATENCY+1 cycles.
- Single-beat vector (valid with last while first=1): pushed sum = result.
- Handshake:
  - Pop when out_valid && out_ready.
  - out_data/out_ovf stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - Push when full with no pop: entry discarded, drop <= 1, accumulator still restarts (first <= 1).
  - Push and pop in the same cycle when full: both occur, no drop, occupancy unchanged.
  - Push and pop in the same cycle when empty: not possible (push becomes visible next cycle); occupancy becomes 1.
  - Pop on empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is 0..FIFO_DEPTH.
  - clear_flags and a drop event in the same cycle: drop = 1 (set wins).
- Reset mid-vector or with beats in flight: all partial sums, tags and buffered entries discarded. Results arriving after reset that belong to pre-reset in_valid are ignored because the tags were cleared.
- Arithmetic is unsigned only; no saturation; out_data wraps modulo 2^ACC_WIDTH with out_ovf=1.

Test Plan:
- Reset check: out_valid=0, drop=0, out_data=0. Then one beat with in_valid=1, in_last=1 and result=0x3_FFFC_0001 after RES_LATENCY cycles -> out_valid at cycle RES_LATENCY+1 with out_data=0x3_FFFC_0001, out_ovf=0.
- Vector of 3 beats, results 10, 20, 30, with a one-cycle in_valid gap between beats 2 and 3 -> single entry of 60; no intermediate out_valid.
- out_ready=0 for 5 back-to-back single-beat vectors (results 1..5), FIFO_DEPTH=4 -> entries 1,2,3,4 retained, drop=1. Raise out_ready -> 1,2,3,4 pop in order. clear_flags -> drop=0.
- Buffer full, then push of 7 with out_ready=1 in the same cycle -> head pops, 7 accepted, drop stays 0, occupancy stays 4.
- ACC_WIDTH=64, RESULT_A_WIDTH=64, two beats of 0xFFFF_FFFF_FFFF_FFFF -> out_data=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1. The next vector of result 5 -> out_data=5, out_ovf=0.
- rst_n asserted after 2 of 3 beats of a vector and released the next cycle, then a fresh single-beat vector of 9 -> only entry is 9. No entry from the interrupted vector and no spurious out_valid.
